// File: rtl/bitrev_reorder_buf_if.sv
// Stream handshake bundle for bitrev_reorder_buf: natural-order input side (s_*)
// and bit-reversed output side (m_*).
interface bitrev_reorder_buf_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/bitrev_reorder_buf.sv
// Ping-pong frame buffer: writes samples in natural order, reads them back in
// bit-reversed order. Optional frame counter output enabled by BITREV_FRAME_CNT_EN.
module bitrev_reorder_buf #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LOG_N_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           cfg_log_n,
`ifdef BITREV_FRAME_CNT_EN
  output logic [15:0]          frame_cnt,
`endif
  bitrev_reorder_buf_if.slave  bus
);

  localparam int unsigned NMax = 2 ** LOG_N_MAX;
  localparam int unsigned LW   = $clog2(LOG_N_MAX + 1);
  localparam int unsigned CW   = LOG_N_MAX;

  typedef enum logic [1:0] {StEmpty, StFilling, StFull} bank_st_e;

  bank_st_e          st_q     [2];
  logic [LW-1:0]     n_q      [2];
  logic [DATA_W-1:0] mem_q    [2][NMax];
  logic              wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     wr_cnt_q, rd_cnt_q;
  logic              init_q;

  logic              s_fire, m_fire;
  logic [LW-1:0]     wr_n, rd_n;
  logic              wr_last, rd_last;
  logic [CW-1:0]     rev_full, rd_addr;

  function automatic logic [LW-1:0] clamp_n(input logic [7:0] cfg);
    if (cfg == 8'd0)                 return LW'(1);
    else if (cfg > 8'(LOG_N_MAX))    return LW'(LOG_N_MAX);
    else                             return cfg[LW-1:0];
  endfunction

  function automatic logic [CW-1:0] last_idx(input logic [LW-1:0] n);
    return ~({CW{1'b1}} << n);
  endfunction

  // A bank's length is taken from cfg_log_n only on its first sample.
  assign wr_n    = (st_q[wr_ptr_q] == StEmpty) ? clamp_n(cfg_log_n) : n_q[wr_ptr_q];
  assign rd_n    = n_q[rd_ptr_q];
  assign wr_last = (wr_cnt_q == last_idx(wr_n));
  assign rd_last = (rd_cnt_q == last_idx(rd_n));

  // Full-width reverse, then shift down so only the low n bits are reversed.
  always_comb begin
    rev_full = '0;
    for (int i = 0; i < int'(CW); i++) begin
      rev_full[i] = rd_cnt_q[CW-1-i];
    end
  end
  assign rd_addr = rev_full >> (LW'(LOG_N_MAX) - rd_n);

  // init_q keeps s_ready low until the first edge after reset release.
  assign bus.s_ready = init_q && (st_q[wr_ptr_q] != StFull);
  assign bus.m_valid = (st_q[rd_ptr_q] == StFull);
  assign bus.m_data  = bus.m_valid ? mem_q[rd_ptr_q][rd_addr] : '0;
  assign bus.m_last  = bus.m_valid && rd_last;

  assign s_fire = bus.s_valid && bus.s_ready;
  assign m_fire = bus.m_valid && bus.m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        st_q[b] <= StEmpty;
        n_q[b]  <= LW'(1);
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      init_q   <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (s_fire) begin
        if (st_q[wr_ptr_q] == StEmpty) begin
          n_q[wr_ptr_q] <= wr_n;
        end
        if (wr_last) begin
          st_q[wr_ptr_q] <= StFull;
          wr_ptr_q       <= ~wr_ptr_q;
          wr_cnt_q       <= '0;
        end else begin
          st_q[wr_ptr_q] <= StFilling;
          wr_cnt_q       <= wr_cnt_q + 1'b1;
        end
      end
      // Read bank is FULL whenever m_fire, so it never collides with the write bank.
      if (m_fire) begin
        if (rd_last) begin
          st_q[rd_ptr_q] <= StEmpty;
          rd_ptr_q       <= ~rd_ptr_q;
          rd_cnt_q       <= '0;
        end else begin
          rd_cnt_q <= rd_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s_fire) begin
      mem_q[wr_ptr_q][wr_cnt_q] <= bus.s_data;
    end
  end

`ifdef BITREV_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 16'd0;
    end else if (m_fire && rd_last) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bitrev_reorder_buf.sv
// Scoreboard bench for bitrev_reorder_buf: frames are pushed as bit-reversed
// expectations on completion and checked as the DUT presents them.
module tb_bitrev_reorder_buf;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned LOG_N_MAX = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cfg_log_n = 8'd0;
`ifdef BITREV_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  bitrev_reorder_buf_if #(.DATA_W(DATA_W)) bus ();

  bitrev_reorder_buf #(
    .DATA_W    (DATA_W),
    .LOG_N_MAX (LOG_N_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_log_n (cfg_log_n),
`ifdef BITREV_FRAME_CNT_EN
    .frame_cnt (frame_cnt),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_bad = 0;
  int         stall_cnt = 0;
  int         frames_out = 0;
  logic [7:0] exp_q [$];
  bit         last_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sends cnt samples base, base+1, ...; only a complete frame is pushed.
  task automatic drive_frame(input logic [7:0] cfg, input int base, input int cnt,
                             input bit chk_early);
    int n, len, w, idx;
    int vals [8];
    n   = (cfg == 8'd0) ? 1 : ((cfg > 8'(LOG_N_MAX)) ? int'(LOG_N_MAX) : int'(cfg));
    len = 1 << n;
    for (int k = 0; k < cnt; k++) begin
      vals[k]     = base + k;
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(base + k);
      // Garbage length after the first sample must be ignored.
      cfg_log_n   = (k == 0) ? cfg : 8'(k + 1);
      w = 0;
      @(negedge clk);
      while (!bus.s_ready && w < 200) begin
        stall_cnt++;
        w++;
        @(negedge clk);
      end
      if (!bus.s_ready) begin
        check("s_ready_timeout", 32'(bus.s_ready), 32'd1);
        bus.s_valid = 1'b0;
        return;
      end
      if (chk_early && k == len - 1) check("m_valid_same_cycle", 32'(bus.m_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b0;
    if (cnt == len) begin
      for (int r = 0; r < len; r++) begin
        idx = 0;
        for (int b = 0; b < n; b++) idx |= ((r >> b) & 1) << (n - 1 - b);
        exp_q.push_back(8'(vals[idx]));
        last_q.push_back(r == len - 1);
      end
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || bus.m_valid) && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Compares every presented sample against the queue head; pops on transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.m_valid) begin
        if (exp_q.size() == 0) begin
          check("m_valid_unexpected", 32'(bus.m_valid), 32'd0);
        end else begin
          check("m_data", 32'(bus.m_data), 32'(exp_q[0]));
          check("m_last", 32'(bus.m_last), 32'(last_q[0]));
          if (bus.m_ready) begin
            void'(exp_q.pop_front());
            if (last_q.pop_front()) frames_out++;
          end
        end
      end
    end
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_last", 32'(bus.m_last), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("s_ready_before_edge", 32'(bus.s_ready), 32'd0);
    @(posedge clk);
    #1;
    check("s_ready_after_edge", 32'(bus.s_ready), 32'd1);

    // Basic 8-point frame and the no-same-cycle m_valid rule.
    bus.m_ready = 1'b1;
    drive_frame(8'd3, 0, 8, 1'b1);
    check("m_valid_next_cycle", 32'(bus.m_valid), 32'd1);
    drain();

    // Short frames, clamp at both ends.
    drive_frame(8'd2, 10, 4, 1'b0);
    drain();
    drive_frame(8'd0, 5, 2, 1'b0);
    drain();
    drive_frame(8'd7, 60, 8, 1'b0);
    drain();

    // Backpressure: both banks fill, then release.
    bus.m_ready = 1'b0;
    drive_frame(8'd3, 20, 8, 1'b0);
    drive_frame(8'd3, 28, 8, 1'b0);
    check("s_ready_both_full", 32'(bus.s_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("m_valid_held", 32'(bus.m_valid), 32'd1);
    bus.m_ready = 1'b1;
    drain();

    // Streaming at full rate must never stall the input.
    stall_cnt = 0;
    drive_frame(8'd3, 0, 8, 1'b0);
    drive_frame(8'd3, 8, 8, 1'b0);
    drive_frame(8'd3, 16, 8, 1'b0);
    check("stream_stalls", 32'(stall_cnt), 32'd0);
    drain();
`ifdef BITREV_FRAME_CNT_EN
    check("frame_cnt", 32'(frame_cnt), 32'(frames_out));
`endif

    // Reset with one full frame held and a partial frame in progress.
    bus.m_ready = 1'b0;
    drive_frame(8'd3, 50, 8, 1'b0);
    drive_frame(8'd3, 40, 5, 1'b0);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    last_q.delete();
    frames_out = 0;
    check("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("mid_rst_s_ready", 32'(bus.s_ready), 32'd0);
`ifdef BITREV_FRAME_CNT_EN
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
    drive_frame(8'd3, 0, 8, 1'b0);
    drain();
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(bus.m_valid), 32'd0);
`ifdef BITREV_FRAME_CNT_EN
    check("frame_cnt_after_rst", 32'(frame_cnt), 32'(frames_out));
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bitrev_reorder_buf.md
BITREV_REORDER_BUF -- requirements
Module: bitrev_reorder_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 8, sample width in bits.
REQ-002 SHALL have parameter LOG_N_MAX, default 3, log2 of maximum frame length (N_MAX = 2**LOG_N_MAX).
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL be updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port cfg_log_n, input, 8, frame length exponent; it SHALL be sampled only at the first accepted sample of each frame.
REQ-006 SHALL have port s_valid, input, 1, input sample valid.
REQ-007 SHALL have port s_ready, output, 1, buffer can accept an input sample.
REQ-008 SHALL have port s_data, input, DATA_W, input sample in natural index order.
REQ-009 SHALL have port m_valid, output, 1, output sample valid.
REQ-010 SHALL have port m_ready, input, 1, downstream accepts the output sample.
REQ-011 SHALL have port m_data, output, DATA_W, output sample in bit-reversed index order.
REQ-012 SHALL have port m_last, output, 1, marks the final sample of an output frame.

Function
REQ-013 SHALL hold two banks of N_MAX x DATA_W registers, used ping-pong; each bank has its own state: EMPTY, FILLING or FULL.
REQ-014 SHALL transfer an input sample only when s_valid and s_ready are both 1, and an output sample only when m_valid and m_ready are both 1.
REQ-015 SHALL define frame length L = 2**n, with n = cfg_log_n clamped to 1..LOG_N_MAX (0 becomes 1; values above LOG_N_MAX become LOG_N_MAX). n SHALL be stored per bank.
REQ-016 SHALL write the k-th accepted sample of a frame to address k of the write bank, then:
  - EMPTY goes to FILLING on k=0;
  - FILLING goes to FULL on k=L-1;
  - on that k=L-1 transfer, the write pointer SHALL toggle to the other bank and the write count SHALL clear.
REQ-017 SHALL drive s_ready=1 exactly when the write bank is EMPTY or FILLING; it SHALL be 0 when both banks are FULL.
REQ-018 SHALL drive m_valid=1 exactly when the read bank is FULL.
REQ-019 SHALL drive m_data from address bitrev_n(r) of the read bank, where r is the read count and bitrev_n reverses the low n bits of r.
REQ-020 SHALL assert m_last when r = L-1 of the read bank.
REQ-021 On the r = L-1 transfer, SHALL set the read bank to EMPTY, toggle the read pointer and clear r.
REQ-022 SHALL assert m_valid for the first output sample in the cycle after the input transfer that completes the frame; it SHALL NOT be asserted in the same cycle.
REQ-023 SHALL keep m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-024 SHALL allow an input transfer and an output transfer in the same cycle on different banks, with no loss.
REQ-025 SHALL sustain 1 sample/cycle in and out when m_ready is held at 1.
REQ-026 SHALL ignore cfg_log_n changes during a frame that is already FILLING.

Reset
REQ-027 While rst_n=0, SHALL immediately set both banks EMPTY, both pointers to bank 0, and both counts to 0.
REQ-028 While rst_n=0, SHALL force s_ready=0, m_valid=0, m_last=0 and m_data=0; s_ready SHALL become 1 on the first clk edge after rst_n rises.
REQ-029 SHALL leave the bank storage registers un-reset.
REQ-030 SHALL discard any partial or full frame when reset is asserted mid-operation; no stale sample SHALL be output after reset.

Configuration
REQ-031 With BITREV_FRAME_CNT_EN defined:
  - SHALL add output port frame_cnt, 16 bits, reset to 0;
  - frame_cnt SHALL increment on each m_last transfer and wrap from 65535 to 0.
REQ-032 Without BITREV_FRAME_CNT_EN, the frame_cnt port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-033 LOG_N_MAX=3, cfg_log_n=3, inputs 0..7, m_ready=1: SHALL output 0,4,2,6,1,5,3,7; m_last only on the 7.
REQ-034 cfg_log_n=2, inputs 10,11,12,13: SHALL output 10,12,11,13; cfg_log_n=0 with inputs 5,6 SHALL output 5,6.
REQ-035 m_ready=0, stream 16 samples (cfg_log_n=3): s_ready SHALL fall after the 16th transfer; releasing m_ready SHALL give both frames bit-reversed, in order.
REQ-036 Continuous input 0..23 with m_ready=1: SHALL have no s_ready deassertion and produce 3 bit-reversed frames back to back.
REQ-037 rst_n pulled low after 5 of 8 samples, then frame 0..7: SHALL output only 0,4,2,6,1,5,3,7.
REQ-038 With BITREV_FRAME_CNT_EN, 3 frames: frame_cnt SHALL read 3; rebuild without the macro SHALL compile with the port absent.
